// File: rtl/pwm_ramp_sequencer.sv
// Register front-end and soft-start sequencer: byte-wide writes set config, per-channel
// targets, step and prescale; live duty commands ramp toward targets once per prescaled tick.
// Optional feature macro: PWM_RAMP_DONE_IRQ_EN adds a one-cycle ramp_done pulse when busy falls.
module pwm_ramp_sequencer #(
   parameter int PRESCALE_W   = 16,
   parameter int PRESCALE_RST = 999,
   parameter int STEP_RST     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic [7:0] PWM_config,
   output logic [7:0] cmd_1,
   output logic [7:0] cmd_2,
   output logic [7:0] cmd_3,
   output logic [7:0] cmd_4,
   output logic       busy
`ifdef PWM_RAMP_DONE_IRQ_EN
  ,output logic       ramp_done
`endif
);

   typedef enum logic {IDLE, STEP} state_t;

   state_t                state_q, state_d;
   logic [1:0]            ch_q, ch_d;
   logic [7:0]            cfg_q, cfg_d;
   logic [7:0]            tgt_q [4];
   logic [7:0]            tgt_d [4];
   logic [7:0]            cmd_q [4];
   logic [7:0]            cmd_d [4];
   logic [7:0]            step_q, step_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic [15:0]           ps_ext;
   logic                  ps_wr;
   logic                  tick;

   // One saturating ramp step; 9-bit intermediates keep the compare free of wrap-around.
   function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt,
                                       input logic [7:0] stp);
      logic [8:0] up;
      logic [8:0] dn;
      logic [7:0] res;
      up  = {1'b0, cur} + {1'b0, stp};
      dn  = {1'b0, cur} - {1'b0, stp};
      res = cur;
      if (stp == 8'd0) begin
         res = tgt;
      end else if (cur < tgt) begin
         res = (up >= {1'b0, tgt}) ? tgt : up[7:0];
      end else if (cur > tgt) begin
         res = (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
      end
      return res;
   endfunction

   always_comb begin
      cfg_d      = cfg_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      ps_ext     = 16'(prescale_q);
      ps_wr      = 1'b0;
      if (wr_en) begin
         case (wr_addr)
            3'd0: cfg_d = wr_data;
            3'd1: tgt_d[0] = wr_data;
            3'd2: tgt_d[1] = wr_data;
            3'd3: tgt_d[2] = wr_data;
            3'd4: tgt_d[3] = wr_data;
            3'd5: step_d = wr_data;
            3'd6: begin ps_ext[7:0]  = wr_data; ps_wr = 1'b1; end
            default: begin ps_ext[15:8] = wr_data; ps_wr = 1'b1; end
         endcase
      end
      prescale_d = PRESCALE_W'(ps_ext);
   end

   always_comb begin
      tick  = (cnt_q == prescale_q);
      cnt_d = (ps_wr || tick) ? '0 : cnt_q + PRESCALE_W'(1);
   end

   // Sequencer: the update reads the pre-write cfg/target/step, so same-cycle writes land next tick.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cmd_d   = cmd_q;
      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = STEP;
               ch_d    = 2'd0;
            end
         end
         default: begin
            if (!cfg_q[3'(ch_q) + 3'd1]) begin
               cmd_d[ch_q] = 8'd0;
            end else begin
               cmd_d[ch_q] = ramp(cmd_q[ch_q], tgt_q[ch_q], step_q);
            end
            ch_d = ch_q + 2'd1;
            if (ch_q == 2'd3) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      busy_d = 1'b0;
      for (int n = 0; n < 4; n++) begin
         busy_d = busy_d | (cfg_d[n+1] & (cmd_d[n] != tgt_d[n]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ch_q       <= 2'd0;
         cfg_q      <= 8'd0;
         step_q     <= 8'(STEP_RST);
         prescale_q <= PRESCALE_W'(PRESCALE_RST);
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            tgt_q[n] <= 8'd0;
            cmd_q[n] <= 8'd0;
         end
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         cfg_q      <= cfg_d;
         step_q     <= step_d;
         prescale_q <= prescale_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         for (int n = 0; n < 4; n++) begin
            tgt_q[n] <= tgt_d[n];
            cmd_q[n] <= cmd_d[n];
         end
      end
   end

`ifdef PWM_RAMP_DONE_IRQ_EN
   logic ramp_done_q, ramp_done_d;

   always_comb begin
      ramp_done_d = busy_q & ~busy_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ramp_done_q <= 1'b0;
      end else begin
         ramp_done_q <= ramp_done_d;
      end
   end

   assign ramp_done = ramp_done_q;
`endif

   assign wr_ready   = 1'b1;
   assign PWM_config = cfg_q;
   assign cmd_1      = cmd_q[0];
   assign cmd_2      = cmd_q[1];
   assign cmd_3      = cmd_q[2];
   assign cmd_4      = cmd_q[3];
   assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed ramp scenarios plus random writes, all checked
// every cycle against an arithmetic model of the tick/slot schedule.
module tb_pwm_ramp_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [7:0] PWM_config;
   logic [7:0] cmd_1, cmd_2, cmd_3, cmd_4;
   logic       busy;
`ifdef PWM_RAMP_DONE_IRQ_EN
   logic       ramp_done;
`endif

   int n_chk = 0;
   int n_bad = 0;

   // reference model state
   int m_cfg, m_step, m_ps, m_cnt, m_slot, m_busy, m_done;
   int m_tgt [4];
   int m_cmd [4];

   pwm_ramp_sequencer #(.PRESCALE_W(16), .PRESCALE_RST(9), .STEP_RST(1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .PWM_config(PWM_config),
      .cmd_1(cmd_1), .cmd_2(cmd_2), .cmd_3(cmd_3), .cmd_4(cmd_4), .busy(busy)
`ifdef PWM_RAMP_DONE_IRQ_EN
     ,.ramp_done(ramp_done)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cfg = 0; m_step = 1; m_ps = 9; m_cnt = 0; m_slot = -1; m_busy = 0; m_done = 0;
      for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_cmd[i] = 0; end
   endtask

   // Called at the clock edge with the inputs that were presented during the cycle.
   task automatic model_step();
      int tick, c, nb;
      if (rst) begin model_reset(); return; end
      tick = (m_cnt == m_ps);
      if (wr_en && (wr_addr == 3'd6 || wr_addr == 3'd7)) m_cnt = 0;
      else if (tick) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (m_slot >= 0) begin
         c = m_slot;
         if (m_cfg[c+1] == 1'b0) m_cmd[c] = 0;
         else if (m_step == 0) m_cmd[c] = m_tgt[c];
         else if (m_cmd[c] < m_tgt[c])
            m_cmd[c] = (m_cmd[c] + m_step > m_tgt[c]) ? m_tgt[c] : m_cmd[c] + m_step;
         else if (m_cmd[c] > m_tgt[c])
            m_cmd[c] = (m_cmd[c] - m_step < m_tgt[c]) ? m_tgt[c] : m_cmd[c] - m_step;
         m_slot = (m_slot == 3) ? -1 : m_slot + 1;
      end else if (tick) begin
         m_slot = 0;
      end
      if (wr_en) begin
         case (wr_addr)
            3'd0: m_cfg = wr_data;
            3'd1, 3'd2, 3'd3, 3'd4: m_tgt[wr_addr - 1] = wr_data;
            3'd5: m_step = wr_data;
            3'd6: m_ps = (m_ps & 'hFF00) | wr_data;
            default: m_ps = (m_ps & 'h00FF) | (int'(wr_data) << 8);
         endcase
      end
      nb = 0;
      for (int i = 0; i < 4; i++) if (m_cfg[i+1] && m_cmd[i] != m_tgt[i]) nb = 1;
      m_done = (m_busy && !nb) ? 1 : 0;
      m_busy = nb;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("cmd_1", cmd_1, m_cmd[0]);
      chk("cmd_2", cmd_2, m_cmd[1]);
      chk("cmd_3", cmd_3, m_cmd[2]);
      chk("cmd_4", cmd_4, m_cmd[3]);
      chk("cfg", PWM_config, m_cfg);
      chk("busy", busy, m_busy);
      chk("wr_ready", wr_ready, 1);
`ifdef PWM_RAMP_DONE_IRQ_EN
      chk("ramp_done", ramp_done, m_done);
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input int a, input int d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   initial begin
      int seq [$];
      int prev, pulses, guard;
      int exp2 [7] = '{16, 32, 48, 64, 80, 96, 100};
      int exp3 [3] = '{60, 20, 5};

      rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
      model_reset();
      run(2);
      rst = 1'b0;
      chk("rst_cmd1", cmd_1, 0);
      chk("rst_cmd4", cmd_4, 0);
      chk("rst_cfg", PWM_config, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_ready", wr_ready, 1);

      // basic ramp up with step 16
      wr(6, 9); wr(7, 0); wr(5, 16); wr(1, 100); wr(0, 2);
      prev = cmd_1; pulses = 0;
      for (int i = 0; i < 150; i++) begin
         cyc();
         if (cmd_1 != prev) seq.push_back(cmd_1);
         prev = cmd_1;
`ifdef PWM_RAMP_DONE_IRQ_EN
         if (ramp_done) pulses++;
`endif
      end
      chk("t2_len", seq.size(), 7);
      for (int i = 0; i < 7 && i < seq.size(); i++) chk("t2_seq", seq[i], exp2[i]);
      chk("t2_busy", busy, 0);
`ifdef PWM_RAMP_DONE_IRQ_EN
      chk("t6_done_pulses", pulses, 1);
`endif

      // ramp down with big step, no underflow
      seq.delete();
      wr(5, 40); wr(1, 5);
      prev = cmd_1;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (cmd_1 != prev) seq.push_back(cmd_1);
         prev = cmd_1;
      end
      chk("t3_len", seq.size(), 3);
      for (int i = 0; i < 3 && i < seq.size(); i++) chk("t3_seq", seq[i], exp3[i]);

      // saturation near 255, then disable mid-ramp
      wr(5, 10); wr(2, 250); wr(0, 4);
      run(300);
      chk("t4_sat", cmd_2, 250);
      wr(2, 20);
      run(30);
      wr(0, 0);
      run(15);
      chk("t4_off", cmd_2, 0);

      // immediate jump, then reset mid-ramp
      wr(5, 0); wr(3, 200); wr(0, 8);
      run(15);
      chk("t5_jump", cmd_3, 200);
      wr(5, 1); wr(3, 0);
      run(30);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t5_rst_cmd3", cmd_3, 0);
      chk("t5_rst_busy", busy, 0);

      // target write coinciding with the ch1 slot uses the old target
      wr(5, 50); wr(1, 200); wr(0, 2);
      chk("t6_pre", cmd_1, 0);
      guard = 0;
      while (m_slot != 0 && guard < 40) begin cyc(); guard++; end
      chk("t6_wait", guard < 40, 1);
      wr(1, 0);
      chk("t6_old_tgt", cmd_1, 50);
      run(15);
      chk("t6_new_tgt", cmd_1, 0);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1; cyc(); rst = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
               0: wr(0, $urandom_range(0, 255));
               1: wr($urandom_range(1, 4), $urandom_range(0, 255));
               2: wr(5, $urandom_range(0, 60));
               3: wr(6, $urandom_range(0, 6));
               4: wr(7, 0);
               default: wr($urandom_range(1, 4), $urandom_range(230, 255));
            endcase
         end else begin
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
